multicycle_control: RTL and testbench

Main control state machine for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and write-back states, and drives every datapath enable and mux select. It sits directly upstream of the ALU control unit and supplies its 3-bit ALUOp. Memory accesses use a ready handshake, so the datapath can be stalled by slow memory.

---
 rtl/multicycle_control.sv | 207 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/memory/write-back.
// Optional jal support is built when MULTICYCLE_JAL_EN is defined.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic [2:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       RegWrite,
  output logic       BranchNE,
  output logic [1:0] PCSource,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    I_EXEC    = 4'd10,
    I_WB      = 4'd11
`ifdef MULTICYCLE_JAL_EN
    , JAL_WB  = 4'd12
`endif
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_JAL_EN
  localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

  state_e     state_q, state_d;
  logic [5:0] opcode_q, opcode_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    ALUOp       = '0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = '0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    RegWrite    = 1'b0;
    BranchNE    = 1'b0;
    PCSource    = '0;
    RegDst      = '0;
    MemtoReg    = '0;
    IllegalOp   = 1'b0;

    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = 3'b100;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        ALUSrcB  = 2'b11;
        ALUOp    = 3'b100;
        opcode_d = Opcode;
        case (Opcode)
          OP_RTYPE:        state_d = R_EXEC;
          OP_LW, OP_SW:    state_d = MEM_ADDR;
          OP_ADDI, OP_ORI: state_d = I_EXEC;
          OP_BEQ, OP_BNE:  state_d = BRANCH;
          OP_J:            state_d = JUMP;
`ifdef MULTICYCLE_JAL_EN
          OP_JAL:          state_d = JAL_WB;
`endif
          default: begin
            IllegalOp = 1'b1;
            state_d   = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = (opcode_q == OP_SW) ? 3'b011 : 3'b010;
        state_d = (opcode_q == OP_SW) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (MemReady) state_d = MEM_WB;
      end
      MEM_WB: begin
        MemtoReg = 2'b01;
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      MEM_WRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (MemReady) state_d = FETCH;
      end
      R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b111;
        state_d = R_WB;
      end
      R_WB: begin
        RegDst   = 2'b01;
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = (opcode_q == OP_ORI) ? 3'b101 : 3'b100;
        state_d = I_WB;
      end
      I_WB: begin
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 3'b001;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        BranchNE    = (opcode_q == OP_BNE);
        state_d     = FETCH;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        state_d  = FETCH;
      end
`ifdef MULTICYCLE_JAL_EN
      JAL_WB: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        RegWrite = 1'b1;
        RegDst   = 2'b10;
        MemtoReg = 2'b10;
        state_d  = FETCH;
      end
`endif
      default: state_d = FETCH;
    endcase

    // Reset silences every output in the same cycle, before the state register has reloaded.
    if (reset) begin
      ALUOp       = '0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = '0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      RegWrite    = 1'b0;
      BranchNE    = 1'b0;
      PCSource    = '0;
      RegDst      = '0;
      MemtoReg    = '0;
      IllegalOp   = 1'b0;
    end
  end

  assign State = reset ? '0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected control words queued at drive time, checked at negedge.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] state;
    logic [2:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       pcwritecond;
    logic       regwrite;
    logic       branchne;
    logic [1:0] pcsource;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       illegal;
  } ctl_t;

  typedef struct {
    ctl_t  v;
    string tag;
  } exp_t;

  localparam ctl_t E_ZERO       = '0;
  localparam ctl_t E_FETCH_RDY  = '{state:4'd0, aluop:3'b100, srcb:2'b01, memread:1'b1, irwrite:1'b1, pcwrite:1'b1, default:'0};
  localparam ctl_t E_FETCH_WAIT = '{state:4'd0, aluop:3'b100, srcb:2'b01, memread:1'b1, default:'0};
  localparam ctl_t E_DECODE     = '{state:4'd1, aluop:3'b100, srcb:2'b11, default:'0};
  localparam ctl_t E_DECODE_ILL = '{state:4'd1, aluop:3'b100, srcb:2'b11, illegal:1'b1, default:'0};
  localparam ctl_t E_MADDR_LW   = '{state:4'd2, aluop:3'b010, srca:1'b1, srcb:2'b10, default:'0};
  localparam ctl_t E_MADDR_SW   = '{state:4'd2, aluop:3'b011, srca:1'b1, srcb:2'b10, default:'0};
  localparam ctl_t E_MEM_READ   = '{state:4'd3, iord:1'b1, memread:1'b1, default:'0};
  localparam ctl_t E_MEM_WB     = '{state:4'd4, regwrite:1'b1, memtoreg:2'b01, default:'0};
  localparam ctl_t E_MEM_WRITE  = '{state:4'd5, iord:1'b1, memwrite:1'b1, default:'0};
  localparam ctl_t E_R_EXEC     = '{state:4'd6, aluop:3'b111, srca:1'b1, default:'0};
  localparam ctl_t E_R_WB       = '{state:4'd7, regwrite:1'b1, regdst:2'b01, default:'0};
  localparam ctl_t E_BEQ        = '{state:4'd8, aluop:3'b001, srca:1'b1, pcwritecond:1'b1, pcsource:2'b01, default:'0};
  localparam ctl_t E_BNE        = '{state:4'd8, aluop:3'b001, srca:1'b1, pcwritecond:1'b1, pcsource:2'b01, branchne:1'b1, default:'0};
  localparam ctl_t E_JUMP       = '{state:4'd9, pcwrite:1'b1, pcsource:2'b10, default:'0};
  localparam ctl_t E_ADDI       = '{state:4'd10, aluop:3'b100, srca:1'b1, srcb:2'b10, default:'0};
  localparam ctl_t E_ORI        = '{state:4'd10, aluop:3'b101, srca:1'b1, srcb:2'b10, default:'0};
  localparam ctl_t E_I_WB       = '{state:4'd11, regwrite:1'b1, default:'0};
`ifdef MULTICYCLE_JAL_EN
  localparam ctl_t E_JAL        = '{state:4'd12, pcwrite:1'b1, pcsource:2'b10, regwrite:1'b1, regdst:2'b10, memtoreg:2'b10, default:'0};
`endif

  logic       clk;
  logic       reset;
  logic [5:0] Opcode;
  logic       MemReady;
  logic [2:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, RegWrite, BranchNE;
  logic [1:0] PCSource, RegDst, MemtoReg;
  logic       IllegalOp;
  logic [3:0] State;

  int unsigned n_vec;
  int unsigned n_bad;
  exp_t        sb[$];
  ctl_t        obs;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .RegWrite(RegWrite), .BranchNE(BranchNE),
    .PCSource(PCSource), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .IllegalOp(IllegalOp), .State(State)
  );

  assign obs = {State, ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite, PCWrite,
                PCWriteCond, RegWrite, BranchNE, PCSource, RegDst, MemtoReg, IllegalOp};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle: drive inputs, queue the expected control word, check it at negedge.
  task automatic step(input logic r, input logic [5:0] op, input logic mr, input ctl_t e, input string tag);
    exp_t x;
    exp_t got;
    reset    = r;
    Opcode   = op;
    MemReady = mr;
    x.v   = e;
    x.tag = tag;
    sb.push_back(x);
    @(negedge clk);
    got = sb.pop_front();
    n_vec++;
    if (obs !== got.v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", got.tag, obs, got.v);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 6'b000000, 1'b1, E_ZERO, "reset0");
    step(1'b1, 6'b100011, 1'b1, E_ZERO, "reset1");
  endtask

  task automatic test_rtype();
    step(1'b0, 6'b000000, 1'b1, E_FETCH_RDY, "r.fetch");
    step(1'b0, 6'b000000, 1'b1, E_DECODE,    "r.decode");
    step(1'b0, 6'b111111, 1'b1, E_R_EXEC,    "r.exec");
    step(1'b0, 6'b111111, 1'b1, E_R_WB,      "r.wb");
  endtask

  task automatic test_lw_stall();
    step(1'b0, 6'b000000, 1'b0, E_FETCH_WAIT, "lw.fetch_stall");
    step(1'b0, 6'b000000, 1'b1, E_FETCH_RDY,  "lw.fetch");
    step(1'b0, 6'b100011, 1'b1, E_DECODE,     "lw.decode");
    // Opcode changes after decode must not redirect the instruction in flight.
    step(1'b0, 6'b101011, 1'b1, E_MADDR_LW,   "lw.addr");
    step(1'b0, 6'b101011, 1'b0, E_MEM_READ,   "lw.read_stall0");
    step(1'b0, 6'b101011, 1'b0, E_MEM_READ,   "lw.read_stall1");
    step(1'b0, 6'b101011, 1'b1, E_MEM_READ,   "lw.read");
    step(1'b0, 6'b101011, 1'b1, E_MEM_WB,     "lw.wb");
  endtask

  task automatic test_sw();
    step(1'b0, 6'b101011, 1'b1, E_FETCH_RDY, "sw.fetch");
    step(1'b0, 6'b101011, 1'b1, E_DECODE,    "sw.decode");
    step(1'b0, 6'b100011, 1'b1, E_MADDR_SW,  "sw.addr");
    step(1'b0, 6'b100011, 1'b0, E_MEM_WRITE, "sw.write_stall");
    step(1'b0, 6'b100011, 1'b1, E_MEM_WRITE, "sw.write");
  endtask

  task automatic test_branch();
    step(1'b0, 6'b000101, 1'b1, E_FETCH_RDY, "bne.fetch");
    step(1'b0, 6'b000101, 1'b1, E_DECODE,    "bne.decode");
    step(1'b0, 6'b000100, 1'b0, E_BNE,       "bne.branch");
    step(1'b0, 6'b000100, 1'b1, E_FETCH_RDY, "beq.fetch");
    step(1'b0, 6'b000100, 1'b1, E_DECODE,    "beq.decode");
    step(1'b0, 6'b000101, 1'b1, E_BEQ,       "beq.branch");
  endtask

  task automatic test_imm();
    step(1'b0, 6'b001000, 1'b1, E_FETCH_RDY, "addi.fetch");
    step(1'b0, 6'b001000, 1'b1, E_DECODE,    "addi.decode");
    step(1'b0, 6'b001101, 1'b1, E_ADDI,      "addi.exec");
    step(1'b0, 6'b001101, 1'b1, E_I_WB,      "addi.wb");
    step(1'b0, 6'b001101, 1'b1, E_FETCH_RDY, "ori.fetch");
    step(1'b0, 6'b001101, 1'b1, E_DECODE,    "ori.decode");
    step(1'b0, 6'b001000, 1'b1, E_ORI,       "ori.exec");
    step(1'b0, 6'b001000, 1'b1, E_I_WB,      "ori.wb");
  endtask

  task automatic test_jump();
    step(1'b0, 6'b000010, 1'b1, E_FETCH_RDY, "j.fetch");
    step(1'b0, 6'b000010, 1'b1, E_DECODE,    "j.decode");
    step(1'b0, 6'b000010, 1'b0, E_JUMP,      "j.jump");
  endtask

  task automatic test_illegal();
    step(1'b0, 6'b111111, 1'b1, E_FETCH_RDY,  "ill.fetch");
    step(1'b0, 6'b111111, 1'b1, E_DECODE_ILL, "ill.decode");
    step(1'b0, 6'b111111, 1'b0, E_FETCH_WAIT, "ill.refetch");
  endtask

  task automatic test_jal();
    step(1'b0, 6'b000011, 1'b1, E_FETCH_RDY,  "jal.fetch");
`ifdef MULTICYCLE_JAL_EN
    step(1'b0, 6'b000011, 1'b1, E_DECODE,     "jal.decode");
    step(1'b0, 6'b000000, 1'b1, E_JAL,        "jal.wb");
`else
    step(1'b0, 6'b000011, 1'b1, E_DECODE_ILL, "jal.illegal");
`endif
  endtask

  task automatic test_reset_mid();
    step(1'b0, 6'b101011, 1'b1, E_FETCH_RDY, "rst.fetch");
    step(1'b0, 6'b101011, 1'b1, E_DECODE,    "rst.decode");
    step(1'b0, 6'b101011, 1'b1, E_MADDR_SW,  "rst.addr");
    step(1'b0, 6'b101011, 1'b0, E_MEM_WRITE, "rst.write_stall");
    step(1'b1, 6'b101011, 1'b0, E_ZERO,      "rst.abort");
    step(1'b0, 6'b000000, 1'b1, E_FETCH_RDY, "rst.refetch");
    step(1'b0, 6'b000000, 1'b1, E_DECODE,    "rst.decode2");
  endtask

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    reset    = 1'b1;
    Opcode   = '0;
    MemReady = 1'b0;
    test_reset();
    test_rtype();
    test_lw_stall();
    test_sw();
    test_branch();
    test_imm();
    test_jump();
    test_illegal();
    test_jal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
